data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter UART_DATA_ADDR, default 16'hBF00, UART data register address.
REQ-002 Parameter UART_STAT_ADDR, default 16'hBF01, UART status register address.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 Address  input  16  word address from the EXE/MEM register (ALU result).
REQ-006 WriteData  input  16  store data from the EXE/MEM register.
REQ-007 MemRead  input  1  load request, level, held by pipeline while memBusy=1.
REQ-008 MemWrite  input  1  store request, level, held by pipeline while memBusy=1.
REQ-009 ReadData  output  16  load result to the MEM/WB register.
REQ-010 memBusy  output  1  stall request to the hazard unit (freeze PC, IF/ID, ID/EXE, EXE/MEM).
REQ-011 ram_addr  output  18  SRAM address.
REQ-012 ram_data  inout  16  SRAM/UART shared data bus.
REQ-013 ram_en_n, ram_oe_n, ram_we_n  output  1 each  SRAM chip enable, output enable and write enable, all active-low.
REQ-014 uart_rdn, uart_wrn  output  1 each  UART read and write strobes, active-low.
REQ-015 uart_data_ready, uart_tbre, uart_tsre  input  1 each  UART receive-ready flag, transmit-buffer-empty flag and transmit-shift-empty flag.

Function
REQ-016 FSM states: IDLE, RAM_RD, RAM_WR1, RAM_WR2, UART_RD, UART_WR, DONE.
REQ-017 IDLE: MemWrite=1 has priority over MemRead; both 0 -> stay IDLE; a request latches Address and WriteData.
REQ-018 memBusy is combinational: 1 in IDLE with a request pending and in every state except IDLE/DONE; 0 in DONE.
REQ-019 Target decode: Address==UART_DATA_ADDR -> UART; Address==UART_STAT_ADDR -> status; else SRAM with ram_addr={2'b00,Address}.
REQ-020 SRAM read: IDLE->RAM_RD (en_n=0, oe_n=0) -> DONE; ReadData is registered at the end of RAM_RD; total latency 2 cycles.
REQ-021 SRAM write: IDLE->RAM_WR1 (addr and data driven, we_n=1) -> RAM_WR2 (we_n=0) -> DONE (we_n=1, data still driven for hold time).
REQ-022 UART read: IDLE->UART_RD (ram_en_n=1, uart_rdn=0, ReadData captured from ram_data at end of state) -> DONE.
REQ-023 UART write: IDLE->UART_WR (ram_en_n=1, data driven, uart_wrn=0) -> DONE.
REQ-024 Status read: IDLE->DONE directly, with ReadData={14'b0, uart_data_ready, uart_tbre & uart_tsre}.
REQ-025 A write to UART_STAT_ADDR produces no strobe and goes IDLE->DONE.
REQ-026 DONE->IDLE unconditionally; requests seen in DONE are ignored, because they are the same held request that retires on this edge.
REQ-027 ram_data is driven only in RAM_WR1, RAM_WR2, DONE-after-write and UART_WR; it is high-Z otherwise.
REQ-028 oe_n and we_n are never low together; rdn and wrn are never low together.
REQ-029 ReadData holds its last value when no load completes; stores do not change ReadData.
REQ-030 All strobes are registered outputs (glitch-free).

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE; ReadData=0; ram_en_n=ram_oe_n=ram_we_n=1; uart_rdn=uart_wrn=1; ram_data high-Z; memBusy=0.
REQ-032 Reset mid-access aborts the access; all strobes are deasserted on that same edge and no partial write completes.

Structure
REQ-033 State encodings and the UART address constants go in the shared CPU defines header/package.
REQ-034 One sub-module, sram_port, holds the tri-state buffer and the registered strobe flops; the FSM stays in data_mem_ctrl.

Verification
REQ-035 SRAM store Address=16'h4000, WriteData=16'h1234 -> we_n low exactly 1 cycle (RAM_WR2), ram_addr=18'h04000, memBusy high 3 cycles.
REQ-036 SRAM load of 16'h4000 after REQ-035 -> ReadData=16'h1234 in DONE, memBusy high 2 cycles, oe_n low 1 cycle.
REQ-037 Status load with data_ready=1, tbre=1, tsre=0 -> ReadData=16'h0002; data_ready=0, tbre=tsre=1 -> 16'h0001.
REQ-038 UART store 16'h0041 to 16'hBF00 -> uart_wrn low 1 cycle, ram_en_n=1, ram_data=16'h0041; UART load -> uart_rdn low 1 cycle, byte captured.
REQ-039 MemRead=MemWrite=1 on 16'h0010 -> write sequence only, no oe_n pulse; rst asserted during RAM_WR1 -> we_n never low, state IDLE next cycle.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared CPU memory-side definitions: access FSM encoding, UART address map and
// the status-word packing used on UART status loads.
package data_mem_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_RAM_RD, S_RAM_WR1, S_RAM_WR2, S_UART_RD, S_UART_WR, S_DONE
   } state_t;

   localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
   localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;

   function automatic logic [15:0] uart_status(input logic dr, input logic tbre, input logic tsre);
      return {14'b0, dr, tbre & tsre};
   endfunction

endpackage

// File: rtl/data_mem_ctrl_sram_port.sv
// External bus pins: latched address/store data, registered active-low strobes
// and the tri-state driver for the shared SRAM/UART data bus.
module sram_port (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_cap,
   input  logic [15:0] i_addr,
   input  logic [15:0] i_wdata,
   input  logic        i_en_n,
   input  logic        i_oe_n,
   input  logic        i_we_n,
   input  logic        i_rdn,
   input  logic        i_wrn,
   input  logic        i_drive,
   output logic [17:0] o_ram_addr,
   output logic        o_ram_en_n,
   output logic        o_ram_oe_n,
   output logic        o_ram_we_n,
   output logic        o_uart_rdn,
   output logic        o_uart_wrn,
   inout  wire  [15:0] io_data
);

   logic [15:0] r_addr;
   logic [15:0] r_dout;
   logic        r_drive;

   // Strobe inputs are decoded from the next state, so each flop is already
   // at its in-state level during the state itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr     <= '0;
         r_dout     <= '0;
         r_drive    <= 1'b0;
         o_ram_en_n <= 1'b1;
         o_ram_oe_n <= 1'b1;
         o_ram_we_n <= 1'b1;
         o_uart_rdn <= 1'b1;
         o_uart_wrn <= 1'b1;
      end else begin
         if (i_cap) begin
            r_addr <= i_addr;
            r_dout <= i_wdata;
         end
         r_drive    <= i_drive;
         o_ram_en_n <= i_en_n;
         o_ram_oe_n <= i_oe_n;
         o_ram_we_n <= i_we_n;
         o_uart_rdn <= i_rdn;
         o_uart_wrn <= i_wrn;
      end
   end

   assign o_ram_addr = {2'b00, r_addr};
   assign io_data    = r_drive ? r_dout : 16'bz;

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: sequences SRAM and memory-mapped UART
// accesses and stalls the pipeline until the access retires.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
   parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Address,
   input  logic [15:0] WriteData,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [15:0] ReadData,
   output logic        memBusy,
   output logic [17:0] ram_addr,
   inout  wire  [15:0] ram_data,
   output logic        ram_en_n,
   output logic        ram_oe_n,
   output logic        ram_we_n,
   output logic        uart_rdn,
   output logic        uart_wrn,
   input  logic        uart_data_ready,
   input  logic        uart_tbre,
   input  logic        uart_tsre
);

   state_t r_state;
   state_t w_nx;
   logic   w_accept, w_stat_rd, w_wr_tail;

   assign w_accept  = (r_state == S_IDLE) && (MemRead || MemWrite) && !rst;
   assign w_stat_rd = w_accept && !MemWrite && (Address == UART_STAT_ADDR);

   always_comb begin
      w_nx = r_state;
      case (r_state)
         S_IDLE: begin
            if (MemWrite) begin
               if (Address == UART_DATA_ADDR)      w_nx = S_UART_WR;
               else if (Address == UART_STAT_ADDR) w_nx = S_DONE;
               else                                w_nx = S_RAM_WR1;
            end else if (MemRead) begin
               if (Address == UART_DATA_ADDR)      w_nx = S_UART_RD;
               else if (Address == UART_STAT_ADDR) w_nx = S_DONE;
               else                                w_nx = S_RAM_RD;
            end
         end
         S_RAM_RD:  w_nx = S_DONE;
         S_RAM_WR1: w_nx = S_RAM_WR2;
         S_RAM_WR2: w_nx = S_DONE;
         S_UART_RD: w_nx = S_DONE;
         S_UART_WR: w_nx = S_DONE;
         S_DONE:    w_nx = S_IDLE;
         default:   w_nx = S_IDLE;
      endcase
      if (rst) w_nx = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         ReadData <= '0;
      end else begin
         r_state <= w_nx;
         if (r_state == S_RAM_RD || r_state == S_UART_RD)
            ReadData <= ram_data;
         else if (w_stat_rd)
            ReadData <= uart_status(uart_data_ready, uart_tbre, uart_tsre);
      end
   end

   // The DONE after a store keeps the bus (and SRAM enable) up for hold time.
   assign w_wr_tail = (w_nx == S_DONE) && (r_state == S_RAM_WR2 || r_state == S_UART_WR);
   assign memBusy   = (r_state == S_IDLE) ? (MemRead || MemWrite) : (r_state != S_DONE);

   sram_port u_port (
      .clk        (clk),
      .rst        (rst),
      .i_cap      (w_accept),
      .i_addr     (Address),
      .i_wdata    (WriteData),
      .i_en_n     (!(w_nx == S_RAM_RD || w_nx == S_RAM_WR1 || w_nx == S_RAM_WR2
                     || (w_wr_tail && r_state == S_RAM_WR2))),
      .i_oe_n     (w_nx != S_RAM_RD),
      .i_we_n     (w_nx != S_RAM_WR2),
      .i_rdn      (w_nx != S_UART_RD),
      .i_wrn      (w_nx != S_UART_WR),
      .i_drive    (w_nx == S_RAM_WR1 || w_nx == S_RAM_WR2 || w_nx == S_UART_WR || w_wr_tail),
      .o_ram_addr (ram_addr),
      .o_ram_en_n (ram_en_n),
      .o_ram_oe_n (ram_oe_n),
      .o_ram_we_n (ram_we_n),
      .o_uart_rdn (uart_rdn),
      .o_uart_wrn (uart_wrn),
      .io_data    (ram_data)
   );

endmodule
